// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of a single data memory port.
// One access in flight: IDLE samples requests, ACCESS drives the memory
// for exactly one cycle, RESP returns load data to the winning port.
// All handshake outputs are registered, so there is no combinational
// path from any request input to gnt/rvalid/mem_we.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [2:0]            m0_addrmode,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [2:0]            m1_addrmode,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_A,
    output logic [DATA_WIDTH-1:0] mem_WD,
    output logic [2:0]            mem_AddrMode,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_RD
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_next;

    // Round-robin pointer: port that wins when both request.
    logic ptr, ptr_next;
    // Index of the port owning the in-flight access.
    logic sel, sel_next;
    // Latched direction of the in-flight access (1 = store).
    logic lat_we, lat_we_next;
    // Arbitration result for the current IDLE cycle.
    logic win;

    logic [ADDR_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0] wdata_next;
    logic [2:0]            mode_next;
    logic                  mem_we_next;
    logic [1:0]            gnt, gnt_next;
    logic [1:0]            rvalid, rvalid_next;
    logic [DATA_WIDTH-1:0] rdata0, rdata0_next;
    logic [DATA_WIDTH-1:0] rdata1, rdata1_next;

    assign m0_gnt    = gnt[0];
    assign m1_gnt    = gnt[1];
    assign m0_rvalid = rvalid[0];
    assign m1_rvalid = rvalid[1];
    assign m0_rdata  = rdata0;
    assign m1_rdata  = rdata1;

    // State register; reset also aborts any in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and handshake registers, loaded from the next-state logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr          <= 1'b0;
            sel          <= 1'b0;
            lat_we       <= 1'b0;
            mem_A        <= '0;
            mem_WD       <= '0;
            mem_AddrMode <= '0;
            mem_we       <= 1'b0;
            gnt          <= '0;
            rvalid       <= '0;
            rdata0       <= '0;
            rdata1       <= '0;
        end else begin
            ptr          <= ptr_next;
            sel          <= sel_next;
            lat_we       <= lat_we_next;
            mem_A        <= addr_next;
            mem_WD       <= wdata_next;
            mem_AddrMode <= mode_next;
            mem_we       <= mem_we_next;
            gnt          <= gnt_next;
            rvalid       <= rvalid_next;
            rdata0       <= rdata0_next;
            rdata1       <= rdata1_next;
        end
    end

    // Next-state and next-output logic; registers hold unless updated.
    always_comb begin
        state_next  = state;
        ptr_next    = ptr;
        sel_next    = sel;
        lat_we_next = lat_we;
        addr_next   = mem_A;
        wdata_next  = mem_WD;
        mode_next   = mem_AddrMode;
        mem_we_next = 1'b0;
        gnt_next    = '0;
        rvalid_next = '0;
        rdata0_next = rdata0;
        rdata1_next = rdata1;
        win         = (m0_req && m1_req) ? ptr : m1_req;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    state_next    = ACCESS;
                    sel_next      = win;
                    ptr_next      = ~win;
                    lat_we_next   = win ? m1_we       : m0_we;
                    addr_next     = win ? m1_addr     : m0_addr;
                    wdata_next    = win ? m1_wdata    : m0_wdata;
                    mode_next     = win ? m1_addrmode : m0_addrmode;
                    mem_we_next   = lat_we_next;
                    gnt_next[win] = 1'b1;
                end
            end
            ACCESS: begin
                if (lat_we) begin
                    state_next = IDLE;
                end else begin
                    state_next       = RESP;
                    rvalid_next[sel] = 1'b1;
                    if (sel) begin
                        rdata1_next = mem_RD;
                    end else begin
                        rdata0_next = mem_RD;
                    end
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a small word-addressed memory model.
module tb_data_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [2:0]  m0_addrmode, m1_addrmode;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] mem_A, mem_WD, mem_RD;
    logic [2:0]  mem_AddrMode;
    logic        mem_we;

    int checks = 0;
    int errors = 0;

    bit [31:0] mem_arr [0:63];

    data_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_addrmode(m0_addrmode), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_addrmode(m1_addrmode), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_A(mem_A), .mem_WD(mem_WD), .mem_AddrMode(mem_AddrMode), .mem_we(mem_we),
        .mem_RD(mem_RD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_RD = mem_arr[mem_A[7:2]];
    always @(posedge clk) if (mem_we) mem_arr[mem_A[7:2]] <= mem_WD;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input logic [2:0] mode);
        if (p == 0) begin
            m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_addrmode = mode;
        end else begin
            m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_addrmode = mode;
        end
    endtask

    task automatic do_store(input int p, input logic [31:0] addr, input logic [31:0] wd);
        bit seen = 0;
        tick();
        set_port(p, 1'b1, 1'b1, addr, wd, 3'd2);
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if ((p == 0 && m0_gnt) || (p == 1 && m1_gnt)) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL store_setup_gnt: port %0d got no gnt within 8 cycles, required gnt", p);
        end
        tick();
        set_port(p, 1'b0, 1'b0, addr, wd, 3'd2);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'd0);
        repeat (2) @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 00000",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_we});
        end
        checks++;
        if ({mem_A, mem_WD, mem_AddrMode, m0_rdata, m1_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_data: mem_A=%h mem_WD=%h mode=%h rd0=%h rd1=%h required all 0",
                     mem_A, mem_WD, mem_AddrMode, m0_rdata, m1_rdata);
        end
        rst = 1'b1;
    endtask

    task automatic test_store_load();
        tick();
        set_port(0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, mem_we} !== 3'b101) begin
            errors++;
            $display("FAIL store_gnt: {gnt0,gnt1,we}=%b required 101", {m0_gnt, m1_gnt, mem_we});
        end
        checks++;
        if (mem_A !== 32'h10 || mem_WD !== 32'hDEADBEEF || mem_AddrMode !== 3'd2) begin
            errors++;
            $display("FAIL store_bus: A=%h WD=%h mode=%0d required 10 DEADBEEF 2",
                     mem_A, mem_WD, mem_AddrMode);
        end
        tick();
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, mem_we, m0_rvalid} !== 4'b1000) begin
            errors++;
            $display("FAIL load_gnt: {gnt0,gnt1,we,rv0}=%b required 1000",
                     {m0_gnt, m1_gnt, mem_we, m0_rvalid});
        end
        tick();
        set_port(0, 1'b0, 1'b0, 32'h10, 32'h0, 3'd2);
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid, m0_gnt, mem_we} !== 4'b1000 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL load_resp: {rv0,rv1,gnt0,we}=%b rdata=%h required 1000 DEADBEEF",
                     {m0_rvalid, m1_rvalid, m0_gnt, mem_we}, m0_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b0 || m0_rdata !== 32'hDEADBEEF || mem_A !== 32'h10) begin
            errors++;
            $display("FAIL load_hold: rv0=%b rdata=%h A=%h required 0 DEADBEEF 10",
                     m0_rvalid, m0_rdata, mem_A);
        end
        do_store(1, 32'h20, 32'h12345678);
        do_store(1, 32'h24, 32'hCAFEF00D);
    endtask

    task automatic test_simultaneous_loads();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        checks++;
        if (m0_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h required 0", m0_rdata);
        end
        tick();
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        set_port(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'd2);
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL both_first_gnt: {gnt0,gnt1}=%b required 10", {m0_gnt, m1_gnt});
        end
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b10 || m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL both_m0_resp: {rv0,rv1}=%b rd0=%h required 10 DEADBEEF",
                     {m0_rvalid, m1_rvalid}, m0_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000) begin
            errors++;
            $display("FAIL both_idle_gap: {gnt0,gnt1,rv0,rv1}=%b required 0000",
                     {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid});
        end
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01 || mem_A !== 32'h20) begin
            errors++;
            $display("FAIL both_second_gnt: {gnt0,gnt1}=%b A=%h required 01 20",
                     {m0_gnt, m1_gnt}, mem_A);
        end
        tick();
        m1_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m0_rvalid, m1_rvalid} !== 2'b01 || m1_rdata !== 32'h12345678 ||
            m0_rdata !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL both_m1_resp: {rv0,rv1}=%b rd1=%h rd0=%h required 01 12345678 DEADBEEF",
                     {m0_rvalid, m1_rvalid}, m1_rdata, m0_rdata);
        end
        tick();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int  grants = 0;
        logic prev_we = 1'b0;
        logic exp_port;
        tick();
        set_port(0, 1'b1, 1'b1, 32'h08, 32'hA0A0A0A0, 3'd2);
        set_port(1, 1'b1, 1'b1, 32'h0C, 32'hB1B1B1B1, 3'd2);
        for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
            @(negedge clk);
            checks++;
            if (mem_we && prev_we) begin
                errors++;
                $display("FAIL b2b_we_consecutive: mem_we high two cycles running at cycle %0d", cyc);
            end
            prev_we = mem_we;
            if (m0_gnt || m1_gnt) begin
                exp_port = grants[0];
                checks++;
                if (m0_gnt === m1_gnt || m1_gnt !== exp_port ||
                    mem_WD !== (exp_port ? 32'hB1B1B1B1 : 32'hA0A0A0A0)) begin
                    errors++;
                    $display("FAIL b2b_order: grant %0d {gnt0,gnt1}=%b WD=%h required port %0d",
                             grants, {m0_gnt, m1_gnt}, mem_WD, exp_port);
                end
                grants++;
            end
        end
        checks++;
        if (grants != 8) begin
            errors++;
            $display("FAIL b2b_count: got %0d grants within 40 cycles, required 8", grants);
        end
        tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        tick();
        set_port(1, 1'b1, 1'b1, 32'h30, 32'h55555555, 3'd2);
        tick();
        #1;
        checks++;
        if ({m1_gnt, mem_we} !== 2'b11) begin
            errors++;
            $display("FAIL abort_pre: {gnt1,we}=%b required 11", {m1_gnt, mem_we});
        end
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if ({m0_gnt, m1_gnt, mem_we} !== 3'b000 || mem_A !== 32'h0 || mem_WD !== 32'h0) begin
            errors++;
            $display("FAIL abort_async: {gnt0,gnt1,we}=%b A=%h WD=%h required 000 0 0",
                     {m0_gnt, m1_gnt, mem_we}, mem_A, mem_WD);
        end
        @(negedge clk);
        rst = 1'b1;
        set_port(0, 1'b1, 1'b1, 32'h40, 32'h66666666, 3'd2);
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10 || mem_A !== 32'h40) begin
            errors++;
            $display("FAIL abort_rearb: {gnt0,gnt1}=%b A=%h required 10 40",
                     {m0_gnt, m1_gnt}, mem_A);
        end
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_arr[12] !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_write: mem[0x30]=%h required 0", mem_arr[12]);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01 || mem_A !== 32'h30) begin
            errors++;
            $display("FAIL abort_held_req: {gnt0,gnt1}=%b A=%h required 01 30",
                     {m0_gnt, m1_gnt}, mem_A);
        end
        tick();
        m1_req = 1'b0;
        @(negedge clk);
        // Pointer now favours port 1; a reset must return it to port 0.
        do_store(0, 32'h44, 32'h00000001);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        tick();
        set_port(0, 1'b1, 1'b1, 32'h48, 32'h2, 3'd2);
        set_port(1, 1'b1, 1'b1, 32'h4C, 32'h3, 3'd2);
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10) begin
            errors++;
            $display("FAIL ptr_reset: {gnt0,gnt1}=%b required 10", {m0_gnt, m1_gnt});
        end
        tick();
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_addr_change();
        tick();
        set_port(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'd2);
        tick();
        m1_addr = 32'h24;
        set_port(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b01 || mem_A !== 32'h20) begin
            errors++;
            $display("FAIL addrchg_access: {gnt0,gnt1}=%b A=%h required 01 20",
                     {m0_gnt, m1_gnt}, mem_A);
        end
        tick();
        m1_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m1_rvalid, m0_rvalid, m0_gnt} !== 3'b100 || m1_rdata !== 32'h12345678 ||
            mem_A !== 32'h20) begin
            errors++;
            $display("FAIL addrchg_resp: {rv1,rv0,gnt0}=%b rd1=%h A=%h required 100 12345678 20",
                     {m1_rvalid, m0_rvalid, m0_gnt}, m1_rdata, mem_A);
        end
        tick();
        @(negedge clk);
        checks++;
        if (m0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL addrchg_m0_wait: gnt0=%b required 0", m0_gnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({m0_gnt, m1_gnt} !== 2'b10 || mem_A !== 32'h10) begin
            errors++;
            $display("FAIL addrchg_m0_gnt: {gnt0,gnt1}=%b A=%h required 10 10",
                     {m0_gnt, m1_gnt}, mem_A);
        end
        tick();
        m0_req = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_rvalid !== 1'b1 || m0_rdata !== 32'hDEADBEEF || m1_rdata !== 32'h12345678) begin
            errors++;
            $display("FAIL addrchg_m0_resp: rv0=%b rd0=%h rd1=%h required 1 DEADBEEF 12345678",
                     m0_rvalid, m0_rdata, m1_rdata);
        end
        tick();
        @(negedge clk);
    endtask

    task automatic test_drop_req();
        tick();
        set_port(0, 1'b1, 1'b1, 32'h50, 32'h77777777, 3'd2);
        @(negedge clk);
        m0_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({m0_gnt, m1_gnt, mem_we} !== 3'b000) begin
                errors++;
                $display("FAIL drop_req: cycle %0d {gnt0,gnt1,we}=%b required 000",
                         i, {m0_gnt, m1_gnt, mem_we});
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_simultaneous_loads();
        test_back_to_back();
        test_reset_mid_access();
        test_addr_change();
        test_drop_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
